// File: rtl/monty_38_pkg.sv
`default_nettype none
// ============================================================================
// Module  : monty_38_pkg
// Purpose : Shared constants, derived widths and FSM state type for the
//           38-bit word-level Montgomery reduction controller.
// Revision: 1.0 - initial release
// ============================================================================
package monty_38_pkg;

  localparam int K       = 128;       // product / datapath C width
  localparam int Q_LEN   = 64;        // modulus width
  localparam int R       = 38;        // bits reduced per iteration
  localparam int N_ITER  = 2;         // reduction iterations
  localparam int RED_LAT = 6;         // issue-to-valid latency of the datapath

  localparam int T_W     = K - R;     // datapath result width
  localparam int QH_W    = Q_LEN - R; // modulus high-part width
  localparam int LAT_W   = $clog2(RED_LAT);
  localparam int ITER_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FINAL = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/monty_final_sub.sv
`default_nettype none
// ============================================================================
// Module  : monty_final_sub
// Purpose : Final conditional subtraction: z = (t >= q) ? t - q : t, with
//           q = {qH, 0...0, 1} rebuilt from the modulus high part.
// Revision: 1.0 - initial release
// ============================================================================
module monty_final_sub
  import monty_38_pkg::*;
(
  input  logic [Q_LEN:0]   t,
  input  logic [QH_W-1:0]  qH,
  output logic [Q_LEN-1:0] z
);

  logic [Q_LEN:0]   w_q;
  logic [Q_LEN+1:0] w_diff;
  logic             w_unused_diff_msb;

  assign w_q    = {1'b0, qH, {(R-1){1'b0}}, 1'b1};
  // One extra bit on top of the operands: its value is the borrow (t < q).
  assign w_diff = {1'b0, t} - {1'b0, w_q};

  // t < 2q for legal inputs, so t - q always fits in Q_LEN bits.
  assign w_unused_diff_msb = w_diff[Q_LEN];
  assign z = w_diff[Q_LEN+1] ? t[Q_LEN-1:0] : w_diff[Q_LEN-1:0];

endmodule
`default_nettype wire

// File: rtl/monty_red_ctrl_38.sv
`default_nettype none
// ============================================================================
// Module  : monty_red_ctrl_38
// Purpose : Iteration sequencer and result stage for the 38-bit word-level
//           Montgomery reduction datapath. Returns P * 2^-76 mod q.
//           Optional build macro MONTY_RED_CTRL_STATS_EN adds the stat_ops /
//           stat_sub counters.
// Revision: 1.0 - initial release
// ============================================================================
module monty_red_ctrl_38
  import monty_38_pkg::*;
(
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic [QH_W-1:0]  qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_P,
  output logic [K-1:0]     red_C,
  output logic [QH_W-1:0]  red_qH,
  input  logic [T_W-1:0]   red_T,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_LEN-1:0] out_Z
`ifdef MONTY_RED_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_sub
`endif
);

  state_t             state_q;
  logic [ITER_W-1:0]  iter_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [Q_LEN:0]     t_q;        // only the bits the final stage can see
  logic [K-1:0]       red_C_q;
  logic [QH_W-1:0]    red_qH_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [Q_LEN-1:0]   out_Z_q;
  logic [Q_LEN-1:0]   w_z;

  // q is taken from the registered red_qH so a changing qH input is harmless.
  monty_final_sub u_final_sub (
    .t  (t_q),
    .qH (red_qH_q),
    .z  (w_z)
  );

  // Main sequencer: accept, two issue/wait rounds, final subtract, output hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      lat_cnt_q   <= '0;
      t_q         <= '0;
      red_C_q     <= '0;
      red_qH_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_Z_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            red_C_q    <= in_P;
            red_qH_q   <= qH;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ISSUE;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          lat_cnt_q <= LAT_W'(RED_LAT - 1);
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt_q == '0) begin
            t_q <= red_T[Q_LEN:0];
            if (iter_q < ITER_W'(N_ITER - 1)) begin
              red_C_q <= {{R{1'b0}}, red_T};
              iter_q  <= iter_q + ITER_W'(1);
              state_q <= S_ISSUE;
            end else begin
              state_q <= S_FINAL;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_FINAL: begin
          out_Z_q     <= w_z;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          // Ready is re-raised on the handshake edge so the next product
          // can be accepted in the following cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_Z     = out_Z_q;
  assign red_C     = red_C_q;
  assign red_qH    = red_qH_q;

`ifdef MONTY_RED_CTRL_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_sub_q;
  logic        w_sub_taken;

  // q is never zero, so the subtract path is exactly when z differs from t.
  assign w_sub_taken = (w_z != t_q[Q_LEN-1:0]);

  // Operation and subtract-path counters, free-wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops_q <= '0;
      stat_sub_q <= '0;
    end else begin
      if (state_q == S_OUT && out_ready) begin
        stat_ops_q <= stat_ops_q + 32'd1;
      end
      if (state_q == S_FINAL && w_sub_taken) begin
        stat_sub_q <= stat_sub_q + 32'd1;
      end
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_sub = stat_sub_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_monty_red_ctrl_38.sv
`default_nettype none
// ============================================================================
// Module  : tb_monty_red_ctrl_38
// Purpose : Self-checking bench for monty_red_ctrl_38 with a behavioural
//           reduction-datapath model and a modular-arithmetic reference.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_monty_red_ctrl_38;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [25:0]   qH = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_P = '0;
  logic [127:0]  red_C;
  logic [25:0]   red_qH;
  logic [89:0]   red_T;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_Z;
`ifdef MONTY_RED_CTRL_STATS_EN
  logic [31:0]   stat_ops;
  logic [31:0]   stat_sub;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_ops = 0;
  int exp_sub = 0;
  int stable_bad = 0;

  monty_red_ctrl_38 dut (
    .clk       (clk),
    .rst       (rst),
    .qH        (qH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_P      (in_P),
    .red_C     (red_C),
    .red_qH    (red_qH),
    .red_T     (red_T),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_Z     (out_Z)
`ifdef MONTY_RED_CTRL_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_sub  (stat_sub)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One word-level reduction step: T = (C + q*((-C) mod 2^38)) >> 38
  function automatic logic [89:0] dp(input logic [127:0] c, input logic [25:0] qh);
    logic [128:0] q;
    logic [37:0]  m;
    logic [128:0] s;
    q = {65'b0, qh, 37'b0, 1'b1};
    m = 38'd0 - c[37:0];
    s = {1'b0, c} + q * {91'b0, m};
    return s[127:38];
  endfunction

  // Free-running datapath model: RED_LAT register stages.
  logic [89:0] pipe [0:5];
  always @(posedge clk) begin
    pipe[0] <= dp(red_C, red_qH);
    for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
  end
  assign red_T = pipe[5];

  function automatic logic [63:0] qval(input logic [25:0] qh);
    return {qh, 37'b0, 1'b1};
  endfunction

  // Reference: P * 2^-76 mod q, by reducing mod q and halving mod q 76 times.
  function automatic logic [63:0] ref_red(input logic [25:0] qh, input logic [127:0] p);
    logic [127:0] x;
    logic [65:0]  y;
    logic [65:0]  q;
    q = {2'b0, qval(qh)};
    x = p % {64'b0, qval(qh)};
    y = x[65:0];
    for (int i = 0; i < 76; i++) y = y[0] ? (y + q) >> 1 : y >> 1;
    return y[63:0];
  endfunction

  function automatic bit ref_sub(input logic [25:0] qh, input logic [127:0] p);
    logic [89:0] t;
    t = dp({38'b0, dp(p, qh)}, qh);
    return t >= {26'b0, qval(qh)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_hs();
    out_ready = 1'b1;
    if (out_valid) exp_ops++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [25:0] qh, input logic [127:0] p, input int hold,
                        output logic [63:0] z, output int lat, output logic [127:0] c2);
    int n;
    qH = qh; in_P = p; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; c2 = '0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (lat == 8) c2 = red_C;
    end
    z = out_Z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_Z !== z || !out_valid || in_ready) stable_bad++;
    end
    do_hs();
  endtask

  typedef struct {
    logic [25:0]  qh;
    logic [127:0] p;
    logic [63:0]  z;
    bit           sub;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [63:0]  z;
    logic [127:0] c2;
    logic [127:0] p;
    logic [191:0] bnd;
    logic [25:0]  qh;
    logic [63:0]  z0;
    int           lat;
    int           n;

    tbl[0] = '{qh: 26'd1, p: 128'd1 << 76, z: 64'd1, sub: 1'b0};
    tbl[1] = '{qh: 26'd1, p: 128'd1 << 77, z: 64'd2, sub: 1'b0};
    tbl[2] = '{qh: 26'd1, p: 128'd0,       z: 64'd0, sub: 1'b0};
    tbl[3] = '{qh: 26'd1, p: ((128'd1 << 38) + 128'd1) << 76, z: 64'd0, sub: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_Z", out_Z, 0);
    chk("rst_red_C", red_C, 0);
    chk("rst_red_qH", red_qH, 0);
    rst = 1'b1;
    chk("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", in_ready, 1);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].qh, tbl[i].p, 0, z, lat, c2);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
      chk($sformatf("tbl%0d_lat", i), lat, 15);
      if (tbl[i].sub) exp_sub++;
      if (i == 0) chk("tbl0_iter2_C", c2, 128'd1 << 38);
    end
`ifdef MONTY_RED_CTRL_STATS_EN
    chk("stat_sub_tbl", stat_sub, exp_sub);
    chk("stat_ops_tbl", stat_ops, exp_ops);
`endif

    // Backpressure: out_ready low 10 cycles with a new product waiting
    qH = 26'd1; in_P = 128'd1 << 76; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_valid", out_valid, 1);
    z0 = out_Z;
    in_P = 128'd1 << 77; in_valid = 1'b1;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_Z !== z0 || !out_valid || in_ready) stable_bad++;
    end
    chk("bp_hold_stable", stable_bad, 0);
    chk("bp_z", z0, 1);
    do_hs();
    chk("bp_valid_dropped", out_valid, 0);
    chk("bp_ready_after_hs", in_ready, 1);
    chk("bp_not_accepted_yet", red_C, 128'd1 << 38);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_next", red_C, 128'd1 << 77);
    chk("bp_ready_low", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_second_z", out_Z, 2);
    do_hs();

    // Randomized operations against the reference
    stable_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      qh = ($urandom_range(0, 3) == 0) ? 26'($urandom_range(1, 15)) : 26'($urandom);
      p  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) p = p >> $urandom_range(1, 120);
      bnd = {128'b0, qval(qh)} << 76;
      if ({64'b0, p} >= bnd) p = 128'({64'b0, p} % bnd);
      run_op(qh, p, int'($urandom_range(0, 2)), z, lat, c2);
      chk($sformatf("rnd%0d_z", i), z, ref_red(qh, p));
      if (lat != 15) chk($sformatf("rnd%0d_lat", i), lat, 15);
      if (ref_sub(qh, p)) exp_sub++;
    end
    chk("rnd_hold_stable", stable_bad, 0);
`ifdef MONTY_RED_CTRL_STATS_EN
    chk("stat_sub_rnd", stat_sub, exp_sub);
    chk("stat_ops_rnd", stat_ops, exp_ops);
`endif

    // Reset during iteration-2 WAIT
    qH = 26'd1; in_P = 128'd1 << 76; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;   // early ready must not matter
    repeat (11) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pre_rst_C_iter2", red_C, 128'd1 << 38);
    rst = 1'b0;
    #1;
    exp_ops = 0; exp_sub = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_red_C", red_C, 0);
    chk("midrst_out_Z", out_Z, 0);
`ifdef MONTY_RED_CTRL_STATS_EN
    chk("midrst_stat_ops", stat_ops, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    run_op(26'd1, 128'd1 << 76, 0, z, lat, c2);
    chk("postrst_z", z, 1);
    chk("postrst_lat", lat, 15);
`ifdef MONTY_RED_CTRL_STATS_EN
    chk("postrst_stat_ops", stat_ops, exp_ops);
    chk("postrst_stat_sub", stat_sub, exp_sub);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/monty_red_ctrl_38.md
Name: monty_red_ctrl_38

Overview:
- Iteration sequencer and result stage that drives the 38-bit word-level Montgomery reduction datapath.
- Accepts a 128-bit product over a valid/ready handshake and issues C/qH to the external reduction pipeline.
- Captures T after the fixed pipeline latency, feeds it back for the second iteration, then applies the final conditional subtraction of q.
- Returns P·2^-76 mod q over a valid/ready output handshake. It sits between the multiplier and the consumer of reduced words.

Parameters:
- K, 128, product / datapath C width.
- Q_LEN, 64, modulus width.
- R, 38, bits reduced per iteration.
- N_ITER, 2, reduction iterations; N_ITER·R ≥ Q_LEN.
- RED_LAT, 6, cycles from issuing C to a valid red_T (matches the datapath with FF_OUT=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- qH  in  Q_LEN-R  modulus high part; q = {qH, {(R-1){0}}, 1}; static while busy.
- in_valid  in  1  product valid.
- in_ready  out  1  controller idle, product accepted.
- in_P  in  K  product, value < q·2^(N_ITER·R).
- red_C  out  K  C to reduction datapath.
- red_qH  out  Q_LEN-R  qH to reduction datapath.
- red_T  in  K-R  datapath result, valid RED_LAT cycles after issue.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_Z  out  Q_LEN  reduced result, < q.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low, port names clk and rst.
- Reset values: in_ready=0, out_valid=0, out_Z=0, red_C=0, red_qH=0, state=IDLE, counters=0. in_ready goes to 1 in the first cycle after rst deasserts.
- FSM states: IDLE, ISSUE, WAIT, FINAL, OUT.
- IDLE: in_ready=1.
  - On in_valid&in_ready: register in_P into red_C and qH into red_qH.
  - Set iter=0 and go to ISSUE.
- ISSUE: lasts one cycle (C presented to the datapath). Load lat_cnt=RED_LAT-1 and go to WAIT.
- WAIT: decrement lat_cnt. When lat_cnt==0, capture red_T into t_reg.
  - If iter<N_ITER-1: red_C <= {R'0, red_T} (zero-extended to K), iter++, go to ISSUE.
  - Otherwise go to FINAL.
- FINAL: out_Z <= (t_reg ≥ q) ? t_reg−q : t_reg[Q_LEN-1:0].
  - Compare and subtract use a Q_LEN+1-bit subtractor on t_reg[Q_LEN:0]. Upper bits of t_reg are guaranteed zero for legal inputs.
  - Set out_valid=1 and go to OUT.
- OUT: hold out_Z and out_valid until out_ready. On the handshake: out_valid=0, go to IDLE.
  - in_ready stays 0 in OUT, so there is no overlap with the next operation.
- Latency from the accepting edge to out_valid: N_ITER·(RED_LAT+1)+1 cycles = 15 at defaults.
- red_C and red_qH hold their values throughout WAIT; the datapath is free-running and ignores the unused cycles.
- qH changing while busy is not allowed: it is sampled only at accept, and q is derived from the registered red_qH.
- rst asserted mid-operation aborts immediately: all outputs return to reset values and any in-flight datapath result is ignored.
- out_ready asserted before out_valid has no effect.

Optional Feature:
- Macro: MONTY_RED_CTRL_STATS_EN.
- Enabled: adds outputs stat_ops (32-bit) and stat_sub (32-bit).
  - stat_ops increments on each output handshake.
  - stat_sub increments when FINAL takes the subtract path.
  - Both counters wrap at 2^32 and are cleared by rst.
- Disabled: no such ports or registers, and behaviour is otherwise identical.

Decomposition:
- Package monty_38_pkg holds:
  - constants K, Q_LEN, R, N_ITER, RED_LAT;
  - derived widths (K-R, Q_LEN-R);
  - the FSM state enum.
- One sub-module, monty_final_sub: combinational compare/conditional subtract of q, with inputs t and qH and output z.

Test Plan:
- qH=1 (q=2^38+1), P=2^76 → out_Z=1, out_valid exactly 15 cycles after accept. Iteration-1 red_T=2^38, iteration-2 red_T=1.
- qH=1, P=2^77 → out_Z=2. P=0 → out_Z=0, no subtraction.
- qH=1, P=q·2^76 → pre-subtract t_reg=q, out_Z=0, subtract path taken (stat_sub=1 when MONTY_RED_CTRL_STATS_EN).
- Backpressure: hold out_ready=0 for 10 cycles → out_Z stable, in_ready=0 throughout. A new in_valid is accepted only the cycle after the out handshake.
- Random qH/P (1000 ops) against the bench datapath model T=(C+q·((−C) mod 2^R))>>R, delayed by RED_LAT cycles → out_Z equals P·2^-76 mod q.
- Assert rst in WAIT of iteration 2 → out_valid=0, in_ready=1 the cycle after release. The next op P=2^76 returns 1.
